// File: rtl/mips_pkg.sv
// Shared constants for the MEM/WB stage: control-bundle bit positions and memory FSM states.
// Optional feature macro used by this slice: MISALIGN_TRAP_EN.
package mips_pkg;

    localparam int WB_REGWRITE = 1;
    localparam int WB_MEMTOREG = 0;
    localparam int M_BRANCH    = 2;
    localparam int M_MEMREAD   = 1;
    localparam int M_MEMWRITE  = 0;

    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } memState_e;

    function automatic logic memAccess(input logic [2:0] memCtl);
        return memCtl[M_MEMREAD] | memCtl[M_MEMWRITE];
    endfunction

endpackage

// File: rtl/mem_wb_stage_if.sv
// EX/MEM bundle in, branch redirect and register write-back out.
// With MISALIGN_TRAP_EN defined the bundle also carries the misaligned flag.
interface mem_wb_stage_if;

    logic [1:0]  wb;
    logic [2:0]  mem;
    logic [31:0] brDst;
    logic        zFlag;
    logic [31:0] alu_out;
    logic [31:0] rt;
    logic [4:0]  wrDst;
    logic        pcSrc;
    logic [31:0] ex_mem_pc;
    logic        stall;
    logic [4:0]  write_reg_MEMWB;
    logic [31:0] write_data_WB;
    logic        write_en;
`ifdef MISALIGN_TRAP_EN
    logic        misaligned;

    modport master (
        output wb, mem, brDst, zFlag, alu_out, rt, wrDst,
        input  pcSrc, ex_mem_pc, stall, write_reg_MEMWB, write_data_WB, write_en, misaligned
    );

    modport slave (
        input  wb, mem, brDst, zFlag, alu_out, rt, wrDst,
        output pcSrc, ex_mem_pc, stall, write_reg_MEMWB, write_data_WB, write_en, misaligned
    );
`else
    modport master (
        output wb, mem, brDst, zFlag, alu_out, rt, wrDst,
        input  pcSrc, ex_mem_pc, stall, write_reg_MEMWB, write_data_WB, write_en
    );

    modport slave (
        input  wb, mem, brDst, zFlag, alu_out, rt, wrDst,
        output pcSrc, ex_mem_pc, stall, write_reg_MEMWB, write_data_WB, write_en
    );
`endif

endinterface

// File: rtl/mem_wb_stage_data_mem.sv
// Word-addressed data memory: synchronous write, combinational read, contents never reset.
module data_mem #(
    parameter int DEPTH = 256
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] addr,
    input  logic [31:0]              wdata,
    output logic [31:0]              rdata
);

    logic [31:0] memArray [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            memArray[addr] <= wdata;
        end
    end

    assign rdata = memArray[addr];

endmodule

// File: rtl/mem_wb_stage.sv
// MEM/WB stage: branch redirect, data memory with MEM_LAT wait-state FSM, MEM/WB register.
// Define MISALIGN_TRAP_EN to flag and suppress accesses whose alu_out[1:0] is non-zero.
module mem_wb_stage
    import mips_pkg::*;
#(
    parameter int DEPTH   = 256,
    parameter int MEM_LAT = 0
) (
    input  logic           clk,
    input  logic           rst_n,
    mem_wb_stage_if.slave  bus
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [3:0] LAT_RELOAD = (MEM_LAT > 0) ? 4'(MEM_LAT - 1) : 4'd0;

    memState_e   stateReg, stateNext;
    logic [3:0]  cntReg, cntNext;
    logic        memBusy;
    logic        completeNow;
    logic        isAccess;
    logic        isStore;
    logic        trap;
    logic        memWe;
    logic [AW-1:0] wordAddr;
    logic [31:0] loadData;
    logic [4:0]  writeRegReg;
    logic [31:0] writeDataReg;
    logic        writeEnReg;

    assign isAccess = memAccess(bus.mem);
    // MemWrite wins when both control bits are set.
    assign isStore  = bus.mem[M_MEMWRITE];
    assign wordAddr = bus.alu_out[AW+1:2];

`ifdef MISALIGN_TRAP_EN
    logic misalignedReg;
    assign trap = isAccess & (bus.alu_out[1:0] != 2'b00);
    assign bus.misaligned = misalignedReg;
`else
    assign trap = 1'b0;
`endif

    always_comb begin
        stateNext   = stateReg;
        cntNext     = cntReg;
        memBusy     = 1'b0;
        completeNow = 1'b1;
        case (stateReg)
            IDLE: begin
                if (isAccess && (MEM_LAT > 0)) begin
                    memBusy     = 1'b1;
                    completeNow = 1'b0;
                    cntNext     = LAT_RELOAD;
                    stateNext   = WAIT;
                end
            end
            WAIT: begin
                if (cntReg != 4'd0) begin
                    memBusy     = 1'b1;
                    completeNow = 1'b0;
                    cntNext     = cntReg - 4'd1;
                end else begin
                    stateNext = IDLE;
                end
            end
            default: begin
                stateNext = IDLE;
                cntNext   = 4'd0;
            end
        endcase
    end

    // Reset gating drops a store that is still waiting when rst_n falls.
    assign memWe = rst_n & completeNow & isStore & ~trap;

    data_mem #(
        .DEPTH (DEPTH)
    ) uDataMem (
        .clk   (clk),
        .we    (memWe),
        .addr  (wordAddr),
        .wdata (bus.rt),
        .rdata (loadData)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stateReg     <= IDLE;
            cntReg       <= 4'd0;
            writeRegReg  <= 5'd0;
            writeDataReg <= 32'd0;
            writeEnReg   <= 1'b0;
`ifdef MISALIGN_TRAP_EN
            misalignedReg <= 1'b0;
`endif
        end else begin
            stateReg <= stateNext;
            cntReg   <= cntNext;
            if (completeNow) begin
                writeRegReg  <= bus.wrDst;
                writeDataReg <= bus.wb[WB_MEMTOREG] ? loadData : bus.alu_out;
                writeEnReg   <= bus.wb[WB_REGWRITE] & (bus.wrDst != 5'd0) & ~trap;
`ifdef MISALIGN_TRAP_EN
                misalignedReg <= trap;
`endif
            end else begin
                writeEnReg <= 1'b0;
`ifdef MISALIGN_TRAP_EN
                misalignedReg <= 1'b0;
`endif
            end
        end
    end

    assign bus.pcSrc           = rst_n & bus.mem[M_BRANCH] & bus.zFlag;
    assign bus.ex_mem_pc       = bus.brDst;
    assign bus.stall           = rst_n & memBusy;
    assign bus.write_reg_MEMWB = writeRegReg;
    assign bus.write_data_WB   = writeDataReg;
    assign bus.write_en        = writeEnReg;

endmodule

// File: doc/mem_wb_stage.md
Name: mem_wb_stage

Overview:
- Consumer end of the EX/MEM interface driven by the IF/ID/EX datapath. Takes the registered EX/MEM bundle (wb, mem, brDst, zFlag, alu_out, rt, wrDst).
- Returns the branch redirect (pcSrc, ex_mem_pc) to fetch, and the register write-back triple (write_reg_MEMWB, write_data_WB, write_en) to decode.
- Contains the data memory, a latency FSM with stall output, and the MEM/WB pipeline register.

Parameters:
- DEPTH, 256, data memory depth in 32-bit words (power of 2).
- MEM_LAT, 0, extra wait cycles per load/store (0..15).

Ports:
- clk  in  1  pipeline clock, rising edge
- rst_n  in  1  synchronous active-low reset
- wb  in  2  {RegWrite, MemtoReg}
- mem  in  3  {Branch, MemRead, MemWrite}
- brDst  in  32  branch target
- zFlag  in  1  ALU zero
- alu_out  in  32  ALU result / memory byte address
- rt  in  32  store data
- wrDst  in  5  destination register
- pcSrc  out  1  take branch
- ex_mem_pc  out  32  branch target to fetch
- stall  out  1  memory busy; upstream must hold EX/MEM inputs stable
- write_reg_MEMWB  out  5  write-back register index
- write_data_WB  out  32  write-back data
- write_en  out  1  register-file write enable

Behaviour:
- Reset: one clk edge with rst_n=0 sets all of the following:
  - write_en=0, write_reg_MEMWB=0, write_data_WB=0.
  - FSM=IDLE, cnt=0.
  - Memory contents are not reset.
- While rst_n=0: stall=0 and pcSrc=0.
- Branch path (combinational):
  - pcSrc = rst_n & mem[2] & zFlag.
  - ex_mem_pc = brDst, passed through unconditionally.
- Address: word index = alu_out[log2(DEPTH)+1:2]. Upper bits are ignored (wrap modulo DEPTH). alu_out[1:0] is ignored unless the optional feature is enabled.
- Access = mem[1] | mem[0]. If both are set, the instruction is treated as a store and MemRead is ignored.
- FSM states IDLE and WAIT, with a 4-bit cnt:
  - IDLE, no access: MEM/WB loads normally on the next edge; stall=0.
  - IDLE, access, MEM_LAT=0: completes this cycle; stall=0.
  - IDLE, access, MEM_LAT>0: stall=1; cnt<=MEM_LAT-1; go to WAIT; MEM/WB loads a bubble (write_en<=0).
  - WAIT, cnt!=0: stall=1; cnt<=cnt-1; bubble.
  - WAIT, cnt==0: stall=0; complete; go to IDLE.
  - Result: an access presented in cycle 0 keeps stall high for cycles 0..MEM_LAT-1 and completes at the end of cycle MEM_LAT.
- Completion:
  - Store: writes rt to the array on the completing edge only.
  - Load: reads the array word at that address (read-before-write is irrelevant because stores never load MEM/WB data).
- MEM/WB register, updated on the completing (non-bubble) edge:
  - write_reg_MEMWB <= wrDst.
  - write_data_WB <= wb[0] ? load data : alu_out.
  - write_en <= wb[1] & (wrDst!=0).
- Latency: results are visible 1 cycle after presentation (MEM_LAT=0), or MEM_LAT+1 cycles after presentation otherwise.
- Reset during WAIT: the pending store is dropped (array unchanged) and the FSM returns to IDLE.
- Back-to-back accesses: the next access is sampled in the IDLE cycle that follows completion, with no extra gap.

Optional Feature:
- Macro: MISALIGN_TRAP_EN.
- Enabled:
  - Adds output port misaligned (1 bit, registered alongside MEM/WB, reset 0).
  - misaligned is set when an access has alu_out[1:0]!=0.
  - That access suppresses its memory write and forces write_en<=0.
  - Latency is unchanged.
- Disabled: the port is absent and low address bits are ignored.

Decomposition:
- Package mips_pkg holds:
  - Bit-index constants: WB_REGWRITE=1, WB_MEMTOREG=0, M_BRANCH=2, M_MEMREAD=1, M_MEMWRITE=0.
  - FSM state encoding.
- Sub-module data_mem (parameter DEPTH): synchronous write and combinational read port.
- FSM, counter and MEM/WB register stay in mem_wb_stage.

Test Plan:
- Reset: hold rst_n=0 for 2 edges with mem=3'b100, zFlag=1 -> pcSrc=0, stall=0, write_en=0, write_reg_MEMWB=0, write_data_WB=0.
- R-type: wb=2'b10, mem=0, alu_out=0x1234, wrDst=5 -> next cycle write_en=1, write_reg_MEMWB=5, write_data_WB=0x1234. Repeat with wrDst=0 -> write_en=0.
- Store then load, MEM_LAT=0:
  - sw mem=3'b001, alu_out=0x10, rt=0xDEADBEEF.
  - lw wb=2'b11, mem=3'b010, alu_out=0x10, wrDst=8.
  - Expect write_data_WB=0xDEADBEEF and write_en=1, one cycle after the lw is presented; stall never asserts.
- MEM_LAT=2, lw to a preloaded word 0xCAFEF00D -> stall=1 for exactly 2 cycles, write_en=0 during those cycles, data appears at cycle 3.
- Branch: mem=3'b100, zFlag=1, brDst=0x40 -> same-cycle pcSrc=1, ex_mem_pc=0x40. With zFlag=0 -> pcSrc=0.
- MEM_LAT=3 sw to 0x20, rst_n=0 in cycle 1 -> word 0x20 unchanged and FSM back in IDLE. With MISALIGN_TRAP_EN, sw at alu_out=0x22 -> misaligned=1 and memory unchanged.
